// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/issue sequencer.
package cpu_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ACK = 3'd2,
    ISSUE    = 3'd3,
    TRAP     = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam int unsigned PC_INCR = 4;
endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential (PC+4) or branch (PC+ImmOp), with alignment flag.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  pcsrc_i,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output logic                  misaligned_o
);
  // Both sums wrap modulo 2^DATA_WIDTH by construction.
  assign next_pc_o    = pcsrc_i ? (pc_i + imm_i) : (pc_i + DATA_WIDTH'(PC_INCR));
  assign misaligned_o = |next_pc_o[1:0];
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches from instruction memory, issues to decode,
// selects the next PC and raises sticky traps on misalignment or fetch timeout.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  output logic                  instr_valid,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] PC,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] retire_count,
  output logic [2:0]            state_dbg
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  // Handshakes: imem_req is a level held from FETCH until the first cycle with
  // imem_req && imem_ack, with imem_addr stable throughout; decode consumes the
  // instruction on the first cycle with instr_valid && !stall.
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   retire_q, retire_d;
  logic                    trap_q, trap_d;
  logic [1:0]              cause_q, cause_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]   next_pc;
  logic                    misaligned;

  next_pc_calc #(.DATA_WIDTH(DATA_WIDTH)) u_next_pc (
    .pc_i        (pc_q),
    .imm_i       (ImmOp),
    .pcsrc_i     (PCsrc),
    .next_pc_o   (next_pc),
    .misaligned_o(misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      retire_q <= '0;
      trap_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_d = retire_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        tmo_d   = '0;
        state_d = imem_ack ? ISSUE : WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack on the limit cycle still wins over the timeout.
        if (imem_ack) begin
          state_d = ISSUE;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_LIMIT) begin
            state_d = TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ISSUE: begin
        if (!stall) begin
          retire_d = retire_q + DATA_WIDTH'(1);
          if (misaligned) begin
            state_d = TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            pc_d    = next_pc;
            state_d = run ? FETCH : IDLE;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req     = (state_q == FETCH) || (state_q == WAIT_ACK);
  assign instr_valid  = (state_q == ISSUE);
  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign trap         = trap_q;
  assign trap_cause   = cause_q;
  assign retire_count = retire_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branches and wrap,
// wait/stall timing, fetch timeout, misaligned trap and async reset.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] PC;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retire_count;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_valid(instr_valid), .stall(stall), .PCsrc(PCsrc),
    .ImmOp(ImmOp), .PC(PC), .trap(trap), .trap_cause(trap_cause),
    .retire_count(retire_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset(input logic run_v, input logic ack_v);
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    @(negedge clk);
    @(negedge clk);
    run = run_v; imem_ack = ack_v;
    rst = 1'b0;
  endtask

  // Waits for the next ISSUE cycle, retires it with the given branch inputs.
  task automatic step_instr(input logic src, input logic [31:0] imm);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL issue_wait: instr_valid never rose, got 0 required 1");
    end
    PCsrc = src; ImmOp = imm;
    @(negedge clk);
    PCsrc = 1'b0; ImmOp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, trap, trap_cause, PC, retire_count, state_dbg} !==
        {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'(IDLE)}) begin
      errors++;
      $display("FAIL reset_state: req=%b iv=%b trap=%b cause=%b pc=%h ret=%h st=%0d required all zero/IDLE",
               imem_req, instr_valid, trap, trap_cause, PC, retire_count, state_dbg);
    end
  endtask

  task automatic test_sequential();
    do_reset(1'b1, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      checks++;
      if ({PC, instr_valid, imem_req} !== {32'((n - 1) / 2 * 4), (n % 2 == 0), (n % 2 == 1)}) begin
        errors++;
        $display("FAIL seq_cycle%0d: pc=%h iv=%b req=%b required pc=%h iv=%b req=%b", n, PC,
                 instr_valid, imem_req, 32'((n - 1) / 2 * 4), (n % 2 == 0), (n % 2 == 1));
      end
    end
    checks++;
    if (retire_count !== 32'd4) begin
      errors++;
      $display("FAIL seq_retire: got %0d required 4", retire_count);
    end
  endtask

  task automatic test_branch();
    step_instr(1'b1, 32'hFFFF_FFF8);
    checks++;
    if ({PC, trap} !== {32'h0000_0008, 1'b0}) begin
      errors++;
      $display("FAIL branch_back: pc=%h trap=%b required pc=00000008 trap=0", PC, trap);
    end
    step_instr(1'b1, 32'hFFFF_FFF4);
    checks++;
    if (PC !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL branch_neg: got %h required fffffffc", PC);
    end
    step_instr(1'b0, 32'h0000_1234);
    checks++;
    if ({PC, trap, retire_count} !== {32'h0, 1'b0, 32'd7}) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h trap=%b ret=%0d required pc=0 trap=0 ret=7", PC, trap, retire_count);
    end
  endtask

  // Entered at a FETCH cycle with PC=0, retire_count=7.
  task automatic test_wait_stall();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL wait_req%0d: req=%b iv=%b addr=%h required 1 0 00000000", i, imem_req,
                 instr_valid, imem_addr);
      end
      if (i == 3) begin imem_ack = 1'b1; stall = 1'b1; end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({instr_valid, imem_req, PC, retire_count} !== {1'b1, 1'b0, 32'h0, 32'd7}) begin
        errors++;
        $display("FAIL stall_hold%0d: iv=%b req=%b pc=%h ret=%0d required 1 0 00000000 7", j,
                 instr_valid, imem_req, PC, retire_count);
      end
      if (j == 2) stall = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({instr_valid, PC, retire_count} !== {1'b0, 32'h4, 32'd8}) begin
      errors++;
      $display("FAIL stall_release: iv=%b pc=%h ret=%0d required 0 00000004 8", instr_valid, PC, retire_count);
    end
  endtask

  task automatic test_timeout();
    do_reset(1'b1, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, trap} !== {1'b1, 1'b0}) begin
        errors++;
        $display("FAIL tmo_wait%0d: req=%b trap=%b required 1 0", k, imem_req, trap);
      end
    end
    @(negedge clk);
    checks++;
    if ({trap, trap_cause, PC, imem_req, instr_valid} !== {1'b1, 2'b10, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_trap: trap=%b cause=%b pc=%h req=%b iv=%b required 1 10 00000000 0 0",
               trap, trap_cause, PC, imem_req, instr_valid);
    end
    // Ack on the 16th WAIT_ACK cycle beats the timeout.
    do_reset(1'b1, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({trap, trap_cause, instr_valid} !== {1'b0, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL tmo_ack_race: trap=%b cause=%b iv=%b required 0 00 1", trap, trap_cause, instr_valid);
    end
  endtask

  task automatic test_misalign();
    do_reset(1'b1, 1'b1);
    step_instr(1'b1, 32'h0000_0020);
    step_instr(1'b1, 32'h0000_0006);
    checks++;
    if ({trap, trap_cause, PC, retire_count} !== {1'b1, 2'b01, 32'h20, 32'd2}) begin
      errors++;
      $display("FAIL misalign_trap: trap=%b cause=%b pc=%h ret=%0d required 1 01 00000020 2",
               trap, trap_cause, PC, retire_count);
    end
    for (int i = 0; i < 5; i++) begin
      PCsrc = i[0]; ImmOp = 32'h4;
      @(negedge clk);
      checks++;
      if ({trap, trap_cause, PC, retire_count, imem_req, instr_valid} !==
          {1'b1, 2'b01, 32'h20, 32'd2, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL trap_frozen%0d: trap=%b cause=%b pc=%h ret=%0d req=%b iv=%b", i, trap,
                 trap_cause, PC, retire_count, imem_req, instr_valid);
      end
    end
    PCsrc = 1'b0; ImmOp = '0;
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1);
    step_instr(1'b1, 32'h0000_0040);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({PC, imem_req, instr_valid, trap, trap_cause, retire_count, state_dbg} !==
        {32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 3'(IDLE)}) begin
      errors++;
      $display("FAIL async_reset: pc=%h req=%b iv=%b trap=%b cause=%b ret=%0d st=%0d required reset values",
               PC, imem_req, instr_valid, trap, trap_cause, retire_count, state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_valid, PC} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL run_drop_issue: iv=%b pc=%h required 1 00000000", instr_valid, PC);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({PC, imem_req, instr_valid, retire_count, state_dbg} !== {32'h4, 1'b0, 1'b0, 32'd1, 3'(IDLE)}) begin
        errors++;
        $display("FAIL run_drop_idle%0d: pc=%h req=%b iv=%b ret=%0d st=%0d required 00000004 0 0 1 IDLE",
                 i, PC, imem_req, instr_valid, retire_count, state_dbg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wait_stall();
    test_timeout();
    test_misalign();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
